// File: rtl/gpio_config_decoder.sv
// gpio_config_decoder: synchronizes the PS GPIO bus, shifts serial config registers and issues per-channel strobes, trigger and fabric reset.
module gpio_config_decoder #(
    parameter int GPIO_BUS_WIDTH   = 16,
    parameter int CONFIG_REG_WIDTH = 256,
    parameter int NUM_CHANNELS     = 16,
    parameter int ADC_SHIFT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [GPIO_BUS_WIDTH-1:0]   gpio_in,
    output logic [NUM_CHANNELS-1:0]     channel_sel,
    output logic [CONFIG_REG_WIDTH-1:0] cycle_count,
    output logic [ADC_SHIFT_WIDTH-1:0]  adc_shift_val,
    output logic [CONFIG_REG_WIDTH-1:0] adc_num_cycles,
    output logic [CONFIG_REG_WIDTH-1:0] pre_delay_cycles,
    output logic [CONFIG_REG_WIDTH-1:0] post_delay_cycles,
    output logic                        ser_data,
    output logic [NUM_CHANNELS-1:0]     mask_shift,
    output logic [NUM_CHANNELS-1:0]     mux_shift,
    output logic [NUM_CHANNELS-1:0]     lock_shift,
    output logic [NUM_CHANNELS-1:0]     mask_en_shift,
    output logic                        trigger_pulse,
    output logic                        pl_rst_out
);
    localparam int NL = 13;

    logic [NL-1:0] s1_q, s2_q, s3_q, rise;
    logic sd, pl, unused_gpio;
    logic [NUM_CHANNELS-1:0] channel_sel_q, channel_sel_d;
    logic [CONFIG_REG_WIDTH-1:0] cycle_count_q, cycle_count_d, adc_num_q, adc_num_d;
    logic [CONFIG_REG_WIDTH-1:0] pre_delay_q, pre_delay_d, post_delay_q, post_delay_d;
    logic [ADC_SHIFT_WIDTH-1:0] adc_shift_q, adc_shift_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d, mux_q, mux_d, lock_q, lock_d, mask_en_q, mask_en_d;
    logic ser_data_q, trigger_q, trigger_d, pl_rst_q;

    assign unused_gpio = ^gpio_in[GPIO_BUS_WIDTH-1:NL];
    assign rise = s2_q & ~s3_q;
    assign sd   = s2_q[0];
    assign pl   = s2_q[5];

    // Two-stage synchronizer plus one history stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= gpio_in[NL-1:0];
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // MSB-first shifts on each serial clock edge; strobes carry the pre-shift select; fabric reset wins over everything.
    always_comb begin
        channel_sel_d = pl ? '0 : rise[2]  ? {channel_sel_q[NUM_CHANNELS-2:0], sd}    : channel_sel_q;
        cycle_count_d = pl ? '0 : rise[3]  ? {cycle_count_q[CONFIG_REG_WIDTH-2:0], sd} : cycle_count_q;
        adc_shift_d   = pl ? '0 : rise[7]  ? {adc_shift_q[ADC_SHIFT_WIDTH-2:0], sd}    : adc_shift_q;
        adc_num_d     = pl ? '0 : rise[8]  ? {adc_num_q[CONFIG_REG_WIDTH-2:0], sd}     : adc_num_q;
        pre_delay_d   = pl ? '0 : rise[9]  ? {pre_delay_q[CONFIG_REG_WIDTH-2:0], sd}   : pre_delay_q;
        post_delay_d  = pl ? '0 : rise[10] ? {post_delay_q[CONFIG_REG_WIDTH-2:0], sd}  : post_delay_q;
        mask_d        = (rise[1]  && !pl) ? channel_sel_q : '0;
        mux_d         = (rise[4]  && !pl) ? channel_sel_q : '0;
        lock_d        = (rise[11] && !pl) ? channel_sel_q : '0;
        mask_en_d     = (rise[12] && !pl) ? channel_sel_q : '0;
        trigger_d     = rise[6] && !pl;
    end

    // Configuration, strobe and control output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            channel_sel_q <= '0;
            cycle_count_q <= '0;
            adc_shift_q   <= '0;
            adc_num_q     <= '0;
            pre_delay_q   <= '0;
            post_delay_q  <= '0;
            mask_q        <= '0;
            mux_q         <= '0;
            lock_q        <= '0;
            mask_en_q     <= '0;
            trigger_q     <= 1'b0;
            ser_data_q    <= 1'b0;
            pl_rst_q      <= 1'b0;
        end else begin
            channel_sel_q <= channel_sel_d;
            cycle_count_q <= cycle_count_d;
            adc_shift_q   <= adc_shift_d;
            adc_num_q     <= adc_num_d;
            pre_delay_q   <= pre_delay_d;
            post_delay_q  <= post_delay_d;
            mask_q        <= mask_d;
            mux_q         <= mux_d;
            lock_q        <= lock_d;
            mask_en_q     <= mask_en_d;
            trigger_q     <= trigger_d;
            ser_data_q    <= sd;
            pl_rst_q      <= pl;
        end
    end

    assign channel_sel       = channel_sel_q;
    assign cycle_count       = cycle_count_q;
    assign adc_shift_val     = adc_shift_q;
    assign adc_num_cycles    = adc_num_q;
    assign pre_delay_cycles  = pre_delay_q;
    assign post_delay_cycles = post_delay_q;
    assign ser_data          = ser_data_q;
    assign mask_shift        = mask_q;
    assign mux_shift         = mux_q;
    assign lock_shift        = lock_q;
    assign mask_en_shift     = mask_en_q;
    assign trigger_pulse     = trigger_q;
    assign pl_rst_out        = pl_rst_q;
endmodule

// File: tb/tb_gpio_config_decoder.sv
// tb_gpio_config_decoder: directed and randomized bench for the GPIO configuration decoder.
module tb_gpio_config_decoder;
    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] gpio;
    logic [15:0] channel_sel, mask_shift, mux_shift, lock_shift, mask_en_shift;
    logic [255:0] cycle_count, adc_num_cycles, pre_delay_cycles, post_delay_cycles;
    logic [7:0] adc_shift_val;
    logic ser_data, trigger_pulse, pl_rst_out;

    gpio_config_decoder dut (
        .clk(clk), .rst_n(rst_n), .gpio_in(gpio),
        .channel_sel(channel_sel), .cycle_count(cycle_count), .adc_shift_val(adc_shift_val),
        .adc_num_cycles(adc_num_cycles), .pre_delay_cycles(pre_delay_cycles),
        .post_delay_cycles(post_delay_cycles), .ser_data(ser_data),
        .mask_shift(mask_shift), .mux_shift(mux_shift), .lock_shift(lock_shift),
        .mask_en_shift(mask_en_shift), .trigger_pulse(trigger_pulse), .pl_rst_out(pl_rst_out)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int strobe_cycles = 0, trig_cycles = 0, exp_strobes = 0, exp_trig = 0;
    logic [15:0] m_sel;
    logic [255:0] m_cyc, m_adc, m_pre, m_post, r;
    logic [7:0] m_ash;
    int lines[4] = '{1, 4, 11, 12};

    always @(negedge clk) begin
        strobe_cycles += int'(mask_shift != 0) + int'(mux_shift != 0) + int'(lock_shift != 0) + int'(mask_en_shift != 0);
        trig_cycles   += int'(trigger_pulse);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "/channel_sel"}, 256'(channel_sel), 256'(m_sel));
        chk({tag, "/cycle_count"}, cycle_count, m_cyc);
        chk({tag, "/adc_num_cycles"}, adc_num_cycles, m_adc);
        chk({tag, "/pre_delay"}, pre_delay_cycles, m_pre);
        chk({tag, "/post_delay"}, post_delay_cycles, m_post);
        chk({tag, "/adc_shift_val"}, 256'(adc_shift_val), 256'(m_ash));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [15:0] strobe_of(input int line);
        return line == 1 ? mask_shift : line == 4 ? mux_shift : line == 11 ? lock_shift : mask_en_shift;
    endfunction

    task automatic shift_val(input int line, input int n, input logic [255:0] v);
        for (int i = n - 1; i >= 0; i--) begin
            gpio[0] = v[i];
            tick(3);
            gpio[line] = 1'b1;
            tick(3);
            gpio[line] = 1'b0;
            tick(3);
        end
    endtask

    task automatic pulse_strobe(input int line, input logic b);
        gpio[0] = b;
        tick(3);
        gpio[line] = 1'b1;
        tick(3);
        chk($sformatf("strobe%0d", line), 256'(strobe_of(line)), 256'(m_sel));
        chk($sformatf("strobe%0d_only", line), 256'(mask_shift | mux_shift | lock_shift | mask_en_shift), 256'(m_sel));
        chk($sformatf("strobe%0d_ser_data", line), 256'(ser_data), 256'(b));
        tick(1);
        chk($sformatf("strobe%0d_width", line), 256'(strobe_of(line)), 256'(0));
        if (m_sel != 0) exp_strobes++;
        gpio[line] = 1'b0;
        tick(3);
    endtask

    initial begin
        rst_n = 1'b0;
        gpio = 16'($urandom);
        m_sel = '0; m_cyc = '0; m_adc = '0; m_pre = '0; m_post = '0; m_ash = '0;
        repeat (5) begin
            @(negedge clk);
            gpio = 16'($urandom);
        end
        check_regs("reset");
        chk("reset/strobes", 256'(mask_shift | mux_shift | lock_shift | mask_en_shift), 256'(0));
        chk("reset/ctrl", 256'({trigger_pulse, pl_rst_out, ser_data}), 256'(0));
        gpio = '0;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        check_regs("idle");
        chk("idle/ctrl", 256'({trigger_pulse, pl_rst_out, ser_data}), 256'(0));

        shift_val(2, 16, 256'h0004);
        m_sel = 16'h0004;
        check_regs("sel4");
        r = rand256();
        shift_val(2, 20, r);
        m_sel = r[15:0];
        check_regs("sel_overshift");

        shift_val(3, 256, 256'd1000);
        m_cyc = 256'd1000;
        check_regs("cyc1000");
        shift_val(3, 256, 256'd0);
        m_cyc = '0;
        check_regs("cyc0");

        r = rand256(); shift_val(3, 256, r); m_cyc = r;
        r = rand256(); shift_val(8, 256, r); m_adc = r;
        r = rand256() | 256'd1; shift_val(9, 256, r); m_pre = r;
        r = rand256() | 256'd1; shift_val(10, 256, r); m_post = r;
        r = rand256(); shift_val(7, 8, r); m_ash = r[7:0];
        check_regs("rand_load");

        shift_val(2, 16, 256'h0005);
        m_sel = 16'h0005;
        pulse_strobe(1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            r = rand256();
            shift_val(2, 16, r);
            m_sel = r[15:0];
            pulse_strobe(lines[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        end

        shift_val(2, 16, 256'h0005);
        m_sel = 16'h0005;
        gpio[0] = 1'b1;
        tick(3);
        gpio[2] = 1'b1;
        gpio[4] = 1'b1;
        tick(3);
        chk("simul/mux_old_sel", 256'(mux_shift), 256'h0005);
        chk("simul/mask_idle", 256'(mask_shift), 256'(0));
        m_sel = {m_sel[14:0], 1'b1};
        chk("simul/new_sel", 256'(channel_sel), 256'(m_sel));
        exp_strobes++;
        tick(1);
        gpio[2] = 1'b0;
        gpio[4] = 1'b0;
        tick(3);
        check_regs("simul");

        gpio[6] = 1'b1;
        tick(2);
        chk("trig/early", 256'(trigger_pulse), 256'(0));
        tick(1);
        chk("trig/pulse", 256'(trigger_pulse), 256'(1));
        exp_trig++;
        tick(1);
        chk("trig/width", 256'(trigger_pulse), 256'(0));
        tick(46);
        gpio[6] = 1'b0;
        tick(4);
        #1;
        chk("trig/count", 256'(trig_cycles), 256'(exp_trig));
        chk("strobe/count", 256'(strobe_cycles), 256'(exp_strobes));

        gpio[5] = 1'b1;
        tick(2);
        chk("plrst/latency", 256'(pl_rst_out), 256'(0));
        tick(1);
        chk("plrst/high", 256'(pl_rst_out), 256'(1));
        m_sel = '0; m_cyc = '0; m_adc = '0; m_pre = '0; m_post = '0; m_ash = '0;
        check_regs("plrst");
        for (int k = 0; k < 3; k++) begin
            gpio[6] = 1'b1;
            gpio[1] = 1'b1;
            tick(4);
            gpio[6] = 1'b0;
            gpio[1] = 1'b0;
            tick(4);
        end
        shift_val(3, 4, 256'hF);
        check_regs("plrst_hold");
        #1;
        chk("plrst/no_trig", 256'(trig_cycles), 256'(exp_trig));
        chk("plrst/no_strobe", 256'(strobe_cycles), 256'(exp_strobes));
        gpio[5] = 1'b0;
        tick(2);
        chk("plrst/still_high", 256'(pl_rst_out), 256'(1));
        tick(1);
        chk("plrst/low", 256'(pl_rst_out), 256'(0));
        gpio[6] = 1'b1;
        tick(3);
        chk("plrst/trig_after", 256'(trigger_pulse), 256'(1));
        exp_trig++;
        tick(3);
        gpio[6] = 1'b0;
        tick(4);
        #1;
        chk("final/trig_count", 256'(trig_cycles), 256'(exp_trig));

        r = rand256() | 256'd1;
        shift_val(9, 256, r);
        m_pre = r;
        check_regs("reload");
        shift_val(9, 8, 256'hAB);
        rst_n = 1'b0;
        #1;
        m_pre = '0;
        check_regs("async_rst");
        chk("async_rst/ctrl", 256'({trigger_pulse, pl_rst_out, ser_data}), 256'(0));
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gpio_config_decoder.md
# gpio_config_decoder

Fabric-side front end of the PS-to-PL GPIO control bus. It synchronizes the 16-bit GPIO bus into the fabric clock and detects rising edges on each serial-clock line. It shifts `sdata` into the global configuration registers (channel select, run/ADC cycle counts, ADC average shift, pre/post delay). It also issues channel-gated per-channel shift strobes, a one-cycle trigger pulse and a held fabric reset to the downstream DAC/ADC channel controllers.

## Interface
- `GPIO_BUS_WIDTH`, 16, width of GPIO bus.
- `CONFIG_REG_WIDTH`, 256, width of the cycle-count and delay registers.
- `NUM_CHANNELS`, 16, width of the one-hot channel select.
- `ADC_SHIFT_WIDTH`, 8, width of the ADC averaging shift register.

- `clk` in 1: fabric clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `gpio_in` in GPIO_BUS_WIDTH: raw PS GPIO bus, asynchronous to `clk`. Bit map: 0 sdata, 1 mask_clk, 2 channel_sel_clk, 3 cycle_count_clk, 4 mux_set_clk, 5 pl_rst, 6 trigger_line, 7 adc_shift_val_clk, 8 adc_num_cycle_count_clk, 9 pre_delay_cycle_clk, 10 post_delay_cycle_clk, 11 locking_waveform_clk, 12 mask_enable_clk. Bits 13-15 unused.
- `channel_sel` out NUM_CHANNELS: one-hot channel select register.
- `cycle_count` out CONFIG_REG_WIDTH: DAC run cycle count.
- `adc_shift_val` out ADC_SHIFT_WIDTH: ADC averaging shift.
- `adc_num_cycles` out CONFIG_REG_WIDTH: ADC run cycle count.
- `pre_delay_cycles` out CONFIG_REG_WIDTH: pre-trigger delay.
- `post_delay_cycles` out CONFIG_REG_WIDTH: post-run delay.
- `ser_data` out 1: synchronized sdata, aligned with all strobes.
- `mask_shift`, `mux_shift`, `lock_shift`, `mask_en_shift` out NUM_CHANNELS each: per-channel one-cycle shift strobes.
- `trigger_pulse` out 1: one-cycle trigger.
- `pl_rst_out` out 1: synchronous fabric reset, active-high.

## Operation
- All 13 used GPIO bits pass through a 2-FF synchronizer (s1, s2) and a third history register (s3). Rising edge on line i: `s2[i] & ~s3[i]`.
- The shift data bit is `s2[0]`, taken in the same cycle the edge is detected.
- Global register update on its clock edge: `reg <= {reg[W-2:0], bit}`, MSB-first. The PS shifts exactly W bits per register; extra bits shift older bits out the top.
- `channel_sel` shifts on channel_sel_clk edges. It is not checked for one-hot; multiple set bits strobe multiple channels.
- Per-channel strobes: on a mask_clk, mux_set_clk, locking_waveform_clk or mask_enable_clk edge, the matching output is driven to `channel_sel` for exactly one cycle. Otherwise it is 0. `ser_data` is registered alongside so it is valid in the strobe cycle.
- Edges on several serial clocks in the same cycle: each target acts independently and all use the same bit.
- Edges on channel_sel_clk and a per-channel clock in the same cycle: strobes use the pre-shift `channel_sel`.
- `trigger_pulse`: one cycle per trigger_line rising edge. A held-high trigger gives one pulse only.
- `pl_rst_out` follows `s2[5]`, registered. While it is high, all config registers clear to 0 every cycle, and all strobes and `trigger_pulse` are forced to 0. Edges detected while pl_rst is high are discarded.
- `rst_n` low clears the synchronizers, history, all registers and all outputs to 0 asynchronously. Reset mid-shift loses partial data; there is no recovery.

## Timing
- Reset value of every output is 0.
- Latency: a GPIO change first captured in s1 at edge k updates the registers and strobes at edge k+2, visible from k+2 to k+3. Strobes and `trigger_pulse` are exactly 1 cycle wide.
- `pl_rst_out` asserts and deasserts 2 cycles after capture, with no filtering.
- PS requirements:
  - Each serial clock high ≥3 cycles and low ≥3 cycles.
  - sdata stable ≥3 cycles before the clock rising edge and ≥1 cycle after it.
  - Faster toggling is out of spec and may drop edges.
- No backpressure: strobes are fire-and-forget.

## Test plan
- Reset: hold `rst_n` low with random `gpio_in`. All outputs are 0; after release with GPIO idle, outputs stay 0.
- Channel select: shift 16 bits 0x0004 MSB-first on bit 2. `channel_sel`=0x0004, and no other register changes.
- Cycle count: shift 256 bits encoding 1000 on bit 3. `cycle_count`=1000. Then shift 256 bits encoding 0. `cycle_count`=0.
- Strobes: with `channel_sel`=0x0005, one mask_clk pulse and sdata=1 give `mask_shift`=0x0005 for 1 cycle, `ser_data`=1 in that cycle, and the other strobes 0. Simultaneous channel_sel_clk and mux_set_clk edges use the old select.
- Trigger: hold trigger_line high for 50 cycles. Exactly one `trigger_pulse`, 3 cycles after assertion.
- pl_rst: load nonzero delays, assert bit 5, and toggle trigger and mask_clk. Registers go to 0 and there are no pulses. After deassertion, a new trigger produces a pulse.
